// File: rtl/depth_line_streamer.sv
// rtl/depth_line_streamer.sv - ping-pong depth line buffer between the engine cluster and a pixel stream
// Writer fills one bank while the reader streams the other; bank_full hands lines across.
module depth_line_streamer #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int DEPTH_BITS    = 10
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            wr_en,
  input  logic [$clog2(SCREEN_WIDTH)-1:0] wr_addr,
  input  logic [DEPTH_BITS-1:0]           wr_depth,
  input  logic                            line_done,
  output logic                            engine_start,
  output logic                            m_tvalid,
  input  logic                            m_tready,
  output logic [DEPTH_BITS-1:0]           m_tdata,
  output logic                            m_tlast,
  output logic                            m_tuser,
  output logic [1:0]                      bank_full
);
  localparam int AW = $clog2(SCREEN_WIDTH);
  localparam int LW = (SCREEN_HEIGHT > 1) ? $clog2(SCREEN_HEIGHT) : 1;
  localparam logic [AW-1:0] X_LAST = AW'(SCREEN_WIDTH - 1);
  localparam logic [LW-1:0] Y_LAST = LW'(SCREEN_HEIGHT - 1);

  typedef enum logic [1:0] {W_IDLE, W_LAUNCH, W_ARM, W_FILL} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_STREAM} r_state_t;

  w_state_t              w_state;
  r_state_t              r_state;
  logic                  wr_bank;
  logic                  rd_bank;
  logic [AW-1:0]         x;
  logic [LW-1:0]         line_cnt;
  logic [DEPTH_BITS-1:0] mem [2][SCREEN_WIDTH];

  logic                  line_commit;
  logic                  line_release;
  logic                  write_ok;
  logic [AW-1:0]         x_next;
  logic [AW-1:0]         rd_addr;
  logic [DEPTH_BITS-1:0] rd_data;

  assign line_commit  = (w_state == W_FILL) && line_done;
  assign line_release = (r_state == R_STREAM) && m_tready && m_tlast;
  assign write_ok     = wr_en && ((w_state == W_ARM) || (w_state == W_FILL))
                        && (32'(wr_addr) < SCREEN_WIDTH);
  assign x_next       = x + 1'b1;
  // Fetch reads pixel 0; streaming prefetches the pixel after the one on the bus.
  assign rd_addr      = (r_state == R_FETCH) ? '0 : x_next;
  assign rd_data      = mem[rd_bank][rd_addr];

  always_ff @(posedge clk) begin
    if (write_ok) begin
      mem[wr_bank][wr_addr] <= wr_depth;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state      <= W_IDLE;
      wr_bank      <= 1'b0;
      engine_start <= 1'b0;
    end else begin
      engine_start <= 1'b0;
      case (w_state)
        W_IDLE: begin
          if (!bank_full[wr_bank]) begin
            w_state      <= W_LAUNCH;
            engine_start <= 1'b1;
          end
        end
        W_LAUNCH: w_state <= W_ARM;
        W_ARM: begin
          if (!line_done) begin
            w_state <= W_FILL;
          end
        end
        W_FILL: begin
          if (line_done) begin
            w_state <= W_IDLE;
            wr_bank <= ~wr_bank;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= R_IDLE;
      rd_bank  <= 1'b0;
      x        <= '0;
      line_cnt <= '0;
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tlast  <= 1'b0;
      m_tuser  <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (bank_full[rd_bank]) begin
            r_state <= R_FETCH;
            x       <= '0;
          end
        end
        R_FETCH: begin
          m_tdata  <= rd_data;
          m_tvalid <= 1'b1;
          m_tlast  <= (SCREEN_WIDTH == 1);
          m_tuser  <= (line_cnt == '0);
          r_state  <= R_STREAM;
        end
        R_STREAM: begin
          if (m_tready) begin
            if (m_tlast) begin
              m_tvalid <= 1'b0;
              m_tlast  <= 1'b0;
              m_tuser  <= 1'b0;
              rd_bank  <= ~rd_bank;
              line_cnt <= (line_cnt == Y_LAST) ? '0 : line_cnt + 1'b1;
              r_state  <= R_IDLE;
            end else begin
              m_tdata <= rd_data;
              x       <= x_next;
              m_tlast <= (x_next == X_LAST);
              m_tuser <= 1'b0;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Writer and reader always own different banks, so set and clear never collide.
  always_ff @(posedge clk) begin
    if (reset) begin
      bank_full <= 2'b00;
    end else begin
      if (line_commit) begin
        bank_full[wr_bank] <= 1'b1;
      end
      if (line_release) begin
        bank_full[rd_bank] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_depth_line_streamer.sv
// tb/tb_depth_line_streamer.sv - scoreboard bench for depth_line_streamer
module tb_depth_line_streamer;
  typedef struct {
    logic [9:0] data;
    logic       last;
    logic       user;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [9:0] wr_depth;
  logic       line_done;
  logic       engine_start;
  logic       m_tvalid;
  logic       m_tready;
  logic [9:0] m_tdata;
  logic       m_tlast;
  logic       m_tuser;
  logic [1:0] bank_full;

  logic       reset_b;
  logic       wr_en_b;
  logic [2:0] wr_addr_b;
  logic [9:0] wr_depth_b;
  logic       line_done_b;
  logic       engine_start_b;
  logic       m_tvalid_b;
  logic       m_tready_b;
  logic [9:0] m_tdata_b;
  logic       m_tlast_b;
  logic       m_tuser_b;
  logic [1:0] bank_full_b;

  int   checks = 0;
  int   failures = 0;
  int   start_cnt = 0;
  int   starts_used = 0;
  int   exp_line = 0;
  exp_t exp_q[$];

  logic       prev_stall = 1'b0;
  logic [9:0] prev_data = '0;
  logic       prev_last = 1'b0;
  logic       prev_user = 1'b0;

  depth_line_streamer #(.SCREEN_WIDTH(8), .SCREEN_HEIGHT(2), .DEPTH_BITS(10)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_depth(wr_depth),
    .line_done(line_done), .engine_start(engine_start), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tuser(m_tuser),
    .bank_full(bank_full)
  );

  // Non-power-of-two width so that out-of-range x values are representable on wr_addr.
  depth_line_streamer #(.SCREEN_WIDTH(6), .SCREEN_HEIGHT(2), .DEPTH_BITS(10)) dut_b (
    .clk(clk), .reset(reset_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_depth(wr_depth_b),
    .line_done(line_done_b), .engine_start(engine_start_b), .m_tvalid(m_tvalid_b),
    .m_tready(m_tready_b), .m_tdata(m_tdata_b), .m_tlast(m_tlast_b), .m_tuser(m_tuser_b),
    .bank_full(bank_full_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      if (engine_start) start_cnt++;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          checks++;
          if (m_tvalid !== 1'b1 || m_tdata !== prev_data || m_tlast !== prev_last || m_tuser !== prev_user) begin
            failures++;
            $display("FAIL stall_hold got=v%b d%0d l%b u%b exp=v1 d%0d l%b u%b",
                     m_tvalid, m_tdata, m_tlast, m_tuser, prev_data, prev_last, prev_user);
          end
        end
        if (m_tvalid && m_tready) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_pixel got=d%0d exp=none", m_tdata);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (m_tdata !== e.data || m_tlast !== e.last || m_tuser !== e.user) begin
              failures++;
              $display("FAIL pixel got=d%0d l%b u%b exp=d%0d l%b u%b",
                       m_tdata, m_tlast, m_tuser, e.data, e.last, e.user);
            end
          end
        end
        prev_stall = m_tvalid && !m_tready;
        prev_data  = m_tdata;
        prev_last  = m_tlast;
        prev_user  = m_tuser;
      end
    end
  end

  task automatic write_line(input int base, input int step);
    int   n;
    exp_t e;
    n = 0;
    while (start_cnt <= starts_used && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (start_cnt <= starts_used) begin
      failures++;
      $display("FAIL engine_start_wait got=none exp=pulse");
    end
    starts_used++;
    line_done = 1'b0;
    for (int x = 0; x < 8; x++) begin
      @(posedge clk); #1;
      wr_en    = 1'b1;
      wr_addr  = 3'(x);
      wr_depth = 10'(base + x * step);
      e.data   = 10'(base + x * step);
      e.last   = (x == 7);
      e.user   = (exp_line == 0) && (x == 0);
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    wr_en     = 1'b0;
    line_done = 1'b1;
    exp_line  = (exp_line + 1) % 2;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain got=%0d left exp=0", name, exp_q.size());
    end
  endtask

  task automatic test_reset;
    int base;
    reset = 1'b1; line_done = 1'b1; m_tready = 1'b1; wr_en = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if ({engine_start, m_tvalid, m_tdata, m_tlast, m_tuser, bank_full} !== 15'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0", {engine_start, m_tvalid, m_tdata, m_tlast, m_tuser, bank_full});
    end
    reset = 1'b0;
    base = start_cnt;
    checks++;
    if (engine_start !== 1'b0) begin failures++; $display("FAIL start_cycle0 got=%b exp=0", engine_start); end
    @(posedge clk); #1;
    checks++;
    if (engine_start !== 1'b1) begin failures++; $display("FAIL start_cycle1 got=%b exp=1", engine_start); end
    @(posedge clk); #1;
    checks++;
    if (engine_start !== 1'b0) begin failures++; $display("FAIL start_cycle2 got=%b exp=0", engine_start); end
    repeat (6) begin @(posedge clk); #1; end
    checks++;
    if (start_cnt - base !== 1) begin failures++; $display("FAIL start_once got=%0d exp=1", start_cnt - base); end
    starts_used = base;
  endtask

  task automatic test_basic_line;
    m_tready = 1'b1;
    write_line(10, 1);
    @(posedge clk); #1;
    checks++;
    if (bank_full !== 2'b01 || m_tvalid !== 1'b0) begin
      failures++; $display("FAIL basic_full got=%b v%b exp=01 v0", bank_full, m_tvalid);
    end
    @(posedge clk); #1;
    checks++;
    if (m_tvalid !== 1'b0) begin failures++; $display("FAIL basic_fetch got=%b exp=0", m_tvalid); end
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      checks++;
      if (m_tvalid !== 1'b1) begin failures++; $display("FAIL basic_valid_%0d got=%b exp=1", k, m_tvalid); end
    end
    @(posedge clk); #1;
    checks++;
    if (bank_full !== 2'b00 || m_tvalid !== 1'b0) begin
      failures++; $display("FAIL basic_release got=%b v%b exp=00 v0", bank_full, m_tvalid);
    end
    drain("basic");
  endtask

  task automatic test_backpressure;
    int n;
    logic pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    write_line(100, 3);
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      m_tready = pat[n % 4];
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL bp_drain got=%0d left exp=0", exp_q.size()); end
    m_tready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (bank_full !== 2'b00) begin failures++; $display("FAIL bp_release got=%b exp=00", bank_full); end
  endtask

  task automatic test_two_full;
    int s0;
    m_tready = 1'b0;
    write_line(200, 1);
    write_line(300, 2);
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (bank_full !== 2'b11) begin failures++; $display("FAIL both_full got=%b exp=11", bank_full); end
    s0 = start_cnt;
    repeat (10) begin @(posedge clk); #1; end
    checks++;
    if (start_cnt !== s0) begin failures++; $display("FAIL no_third_start got=%0d exp=%0d", start_cnt, s0); end
    m_tready = 1'b1;
    drain("two_full");
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (start_cnt !== s0 + 1) begin failures++; $display("FAIL restart got=%0d exp=%0d", start_cnt, s0 + 1); end
    checks++;
    if (bank_full !== 2'b00) begin failures++; $display("FAIL two_full_release got=%b exp=00", bank_full); end
  endtask

  task automatic test_reset_mid;
    int n;
    m_tready = 1'b1;
    write_line(400, 5);
    drain("pre_reset");
    write_line(500, 1);
    n = 0;
    while (!m_tvalid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (m_tvalid !== 1'b1) begin failures++; $display("FAIL mid_valid got=%b exp=1", m_tvalid); end
    repeat (4) begin @(posedge clk); #1; end
    checks++;
    if (m_tdata !== 10'd504) begin failures++; $display("FAIL mid_x4 got=%0d exp=504", m_tdata); end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({engine_start, m_tvalid, m_tdata, m_tlast, m_tuser, bank_full} !== 15'd0) begin
      failures++;
      $display("FAIL mid_reset_outputs got=%b exp=0", {engine_start, m_tvalid, m_tdata, m_tlast, m_tuser, bank_full});
    end
    exp_q.delete();
    exp_line = 0;
    reset = 1'b0;
    starts_used = start_cnt;
    write_line(600, 7);
    drain("post_reset");
    checks++;
    if (bank_full !== 2'b00) begin failures++; $display("FAIL post_reset_release got=%b exp=00", bank_full); end
  endtask

  task automatic test_out_of_range;
    int n;
    int addr_tab[10] = '{0, 1, 2, 3, 4, 5, 6, 3, 3, 7};
    int val_tab[10]  = '{40, 41, 42, 43, 44, 45, 99, 5, 6, 98};
    int exp_tab[6]   = '{40, 41, 42, 6, 44, 45};
    reset_b = 1'b1; line_done_b = 1'b1; m_tready_b = 1'b1; wr_en_b = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset_b = 1'b0;
    n = 0;
    while (!engine_start_b && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (engine_start_b !== 1'b1) begin failures++; $display("FAIL oor_start got=%b exp=1", engine_start_b); end
    line_done_b = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      wr_en_b = 1'b1; wr_addr_b = 3'(addr_tab[i]); wr_depth_b = 10'(val_tab[i]);
    end
    @(posedge clk); #1;
    wr_en_b = 1'b0; line_done_b = 1'b1;
    n = 0;
    while (!m_tvalid_b && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    for (int x = 0; x < 6; x++) begin
      checks++;
      if (m_tvalid_b !== 1'b1 || m_tdata_b !== 10'(exp_tab[x]) || m_tlast_b !== (x == 5) || m_tuser_b !== (x == 0)) begin
        failures++;
        $display("FAIL oor_pixel_%0d got=v%b d%0d l%b u%b exp=v1 d%0d l%b u%b", x,
                 m_tvalid_b, m_tdata_b, m_tlast_b, m_tuser_b, exp_tab[x], (x == 5), (x == 0));
      end
      @(posedge clk); #1;
    end
    checks++;
    if (bank_full_b !== 2'b00 || m_tvalid_b !== 1'b0) begin
      failures++; $display("FAIL oor_release got=%b v%b exp=00 v0", bank_full_b, m_tvalid_b);
    end
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_depth = '0; line_done = 1'b1; m_tready = 1'b1;
    reset_b = 1'b1; wr_en_b = 1'b0; wr_addr_b = '0; wr_depth_b = '0; line_done_b = 1'b1; m_tready_b = 1'b1;
    test_reset();
    test_basic_line();
    test_backpressure();
    test_two_full();
    test_reset_mid();
    test_out_of_range();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
